// File: rtl/ip1_argmax_pkg.sv
// Shared types and default constants for the ip1 argmax classification stage.
// The defaults match the 10-way fully-connected layer feeding this block.
package ip1_argmax_pkg;

   localparam int NUM_CLASSES_DEF = 10;
   localparam int DW_DEF          = 16;
   localparam int IDX_W_DEF       = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      OUT     = 2'd2
   } state_t;

   // Control of the compare unit: start a new blob, fold in a beat, or keep state.
   typedef enum logic [1:0] {
      OP_HOLD   = 2'd0,
      OP_LOAD   = 2'd1,
      OP_UPDATE = 2'd2
   } cmp_op_t;

endpackage

// File: rtl/argmax_cmp_unit.sv
// Running-maximum datapath: max/idx registers, signed compare, beat counter
// and overflow flag, plus the length-error flag computed for the last beat.
module argmax_cmp_unit
   import ip1_argmax_pkg::*;
#(
   parameter int NUM_CLASSES = NUM_CLASSES_DEF,
   parameter int DW          = DW_DEF,
   parameter int IDX_W       = IDX_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  cmp_op_t              op,
   input  logic signed [DW-1:0] din,
   output logic signed [DW-1:0] max_score,
   output logic [IDX_W-1:0]     max_idx,
   output logic                 err
);

   logic [IDX_W-1:0]     cnt, cnt_n;
   logic                 ovf, ovf_n;
   logic signed [DW-1:0] max_n;
   logic [IDX_W-1:0]     idx_n;
   logic                 err_n;
   logic                 full;

   assign full = (cnt == IDX_W'(NUM_CLASSES));

   always_comb begin
      max_n = max_score;
      idx_n = max_idx;
      cnt_n = cnt;
      ovf_n = ovf;
      case (op)
         OP_LOAD: begin
            max_n = din;
            idx_n = '0;
            cnt_n = IDX_W'(1);
            ovf_n = 1'b0;
         end
         OP_UPDATE: begin
            // Excess beats are not compared; the counter stays saturated.
            if (full) begin
               ovf_n = 1'b1;
            end else begin
               if (din > max_score) begin
                  max_n = din;
                  idx_n = cnt;
               end
               cnt_n = cnt + IDX_W'(1);
            end
         end
         default: ;
      endcase
      // Only meaningful on the eop beat; it is then held while the result waits.
      err_n = (op == OP_HOLD) ? err : (ovf_n | (cnt_n != IDX_W'(NUM_CLASSES)));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         max_score <= '0;
         max_idx   <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         err       <= 1'b0;
      end else begin
         max_score <= max_n;
         max_idx   <= idx_n;
         cnt       <= cnt_n;
         ovf       <= ovf_n;
         err       <= err_n;
      end
   end

endmodule

// File: rtl/ip1_argmax.sv
// Argmax over one blob of NUM_CLASSES signed scores; reports the winning index,
// its score and a length-error flag on a valid/ready result port.
module ip1_argmax
   import ip1_argmax_pkg::*;
#(
   parameter int NUM_CLASSES = NUM_CLASSES_DEF,
   parameter int DW          = DW_DEF,
   parameter int IDX_W       = IDX_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   output logic             blob_din_rdy,
   input  logic             blob_din_en,
   input  logic             blob_din_eop,
   input  logic [DW-1:0]    blob_din,
   output logic             class_valid,
   input  logic             class_ready,
   output logic [IDX_W-1:0] class_idx,
   output logic [DW-1:0]    class_score,
   output logic             class_err,
   output state_t           dbg_state
);

   // Handshakes: the producer waits for blob_din_rdy once, then streams the whole
   // blob with blob_din_en (no per-beat backpressure; eop marks the last beat).
   // The result transfers on a cycle where class_valid and class_ready are both
   // high; class_valid stays up with stable payload until that happens.

   state_t  state, state_next;
   cmp_op_t op;
   logic    signed [DW-1:0] max_score;

   always_comb begin
      state_next = state;
      op         = OP_HOLD;
      case (state)
         IDLE: begin
            if (blob_din_en) begin
               op         = OP_LOAD;
               state_next = blob_din_eop ? OUT : COLLECT;
            end
         end
         COLLECT: begin
            if (blob_din_en) begin
               op = OP_UPDATE;
               if (blob_din_eop) state_next = OUT;
            end
         end
         OUT: begin
            // Beats arriving here violate the protocol and are dropped.
            if (class_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         blob_din_rdy <= 1'b0;
      end else begin
         state        <= state_next;
         blob_din_rdy <= (state_next == IDLE);
      end
   end

   argmax_cmp_unit #(
      .NUM_CLASSES (NUM_CLASSES),
      .DW          (DW),
      .IDX_W       (IDX_W)
   ) u_cmp (
      .clk       (clk),
      .rst       (rst),
      .op        (op),
      .din       (blob_din),
      .max_score (max_score),
      .max_idx   (class_idx),
      .err       (class_err)
   );

   assign class_score = max_score;
   assign class_valid = (state == OUT);
   assign dbg_state   = state;

endmodule

// File: tb/tb_ip1_argmax.sv
// Directed and randomized bench for ip1_argmax with a queue-based reference model.
module tb_ip1_argmax;
   import ip1_argmax_pkg::*;

   localparam int NUM = 10;

   typedef logic [15:0] blob_t[$];

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        blob_din_rdy;
   logic        blob_din_en = 1'b0;
   logic        blob_din_eop = 1'b0;
   logic [15:0] blob_din = '0;
   logic        class_valid;
   logic        class_ready = 1'b0;
   logic [3:0]  class_idx;
   logic [15:0] class_score;
   logic        class_err;
   state_t      dbg_state;

   int n_vec = 0;
   int n_err = 0;
   logic [20:0] exp_q[$];
   logic [20:0] last_exp = '0;

   ip1_argmax dut (
      .clk          (clk),
      .rst          (rst),
      .blob_din_rdy (blob_din_rdy),
      .blob_din_en  (blob_din_en),
      .blob_din_eop (blob_din_eop),
      .blob_din     (blob_din),
      .class_valid  (class_valid),
      .class_ready  (class_ready),
      .class_idx    (class_idx),
      .class_score  (class_score),
      .class_err    (class_err),
      .dbg_state    (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference model: argmax over the first NUM beats, strict > so lowest index wins
   function automatic logic [20:0] ref_model(input blob_t q);
      int n = q.size();
      int lim = (n < NUM) ? n : NUM;
      int best_i = 0;
      int best = $signed(q[0]);
      logic err = (n != NUM);
      for (int i = 1; i < lim; i++) begin
         int v = $signed(q[i]);
         if (v > best) begin
            best   = v;
            best_i = i;
         end
      end
      return {err, 4'(best_i), q[best_i]};
   endfunction

   function automatic logic [15:0] rand_score();
      int v = int'($urandom_range(0, 200)) - 100;
      return 16'(v);
   endfunction

   function automatic blob_t rand_blob(input int n);
      blob_t q;
      for (int i = 0; i < n; i++) q.push_back(rand_score());
      return q;
   endfunction

   task automatic check_result();
      logic [20:0] e;
      e = exp_q.pop_front();
      last_exp = e;
      chk("valid", 32'(class_valid), 32'd1);
      chk("idx",   32'(class_idx),   32'(e[19:16]));
      chk("score", 32'(class_score), 32'(e[15:0]));
      chk("err",   32'(class_err),   32'(e[20]));
      chk("rdy_in_out", 32'(blob_din_rdy), 32'd0);
   endtask

   // driver: streams one blob (optionally with en gaps), then checks the result
   task automatic send_blob(input blob_t q, input bit gaps);
      exp_q.push_back(ref_model(q));
      for (int i = 0; i < q.size(); i++) begin
         if (gaps && $urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 3)) begin
               blob_din = 16'($urandom_range(0, 65535));
               @(posedge clk); #1;
            end
         end
         blob_din_en  = 1'b1;
         blob_din     = q[i];
         blob_din_eop = (i == q.size() - 1);
         if (i == q.size() - 1) chk("valid_before_eop", 32'(class_valid), 32'd0);
         @(posedge clk); #1;
         blob_din_en  = 1'b0;
         blob_din_eop = 1'b0;
         if (i == 0) chk("rdy_after_beat1", 32'(blob_din_rdy), 32'd0);
      end
      check_result();
   endtask

   task automatic accept();
      class_ready = 1'b1;
      @(posedge clk); #1;
      class_ready = 1'b0;
      chk("valid_after_accept", 32'(class_valid), 32'd0);
      chk("rdy_after_accept", 32'(blob_din_rdy), 32'd1);
   endtask

   task automatic hold(input int cycles, input bit pulses);
      for (int c = 0; c < cycles; c++) begin
         if (pulses) begin
            blob_din_en  = 1'($urandom_range(0, 1));
            blob_din_eop = 1'($urandom_range(0, 1));
            blob_din     = 16'h7fff;
         end
         @(posedge clk); #1;
         chk("hold_valid", 32'(class_valid), 32'd1);
         chk("hold_idx",   32'(class_idx),   32'(last_exp[19:16]));
         chk("hold_score", 32'(class_score), 32'(last_exp[15:0]));
         chk("hold_err",   32'(class_err),   32'(last_exp[20]));
      end
      blob_din_en  = 1'b0;
      blob_din_eop = 1'b0;
   endtask

   initial begin
      blob_t nominal, q;
      nominal = '{16'd5, -16'sd3, 16'd100, 16'd7, 16'd0, 16'd99, 16'd2, 16'd1, -16'sd50, 16'd8};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdy",   32'(blob_din_rdy), 32'd0);
      chk("rst_valid", 32'(class_valid),  32'd0);
      chk("rst_idx",   32'(class_idx),    32'd0);
      chk("rst_score", 32'(class_score),  32'd0);
      chk("rst_err",   32'(class_err),    32'd0);
      chk("rst_state", 32'(dbg_state),    32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rdy_after_rst", 32'(blob_din_rdy), 32'd1);

      // nominal blob, then backpressure and stray beats while the result waits
      send_blob(nominal, 1'b0);
      hold(20, 1'b0);
      hold(8, 1'b1);
      accept();

      // negatives with a tie, then maximum on the last index
      q = '{NUM{-16'sd20}};
      q[4] = 16'hffff;
      q[7] = 16'hffff;
      send_blob(q, 1'b0);
      accept();
      q = rand_blob(NUM);
      q[9] = 16'h7fff;
      send_blob(q, 1'b0);
      accept();

      // length errors, each followed by a clean blob
      send_blob(rand_blob(8), 1'b0);
      accept();
      send_blob(rand_blob(NUM), 1'b0);
      accept();
      q = rand_blob(12);
      q[10] = 16'h7fff;
      send_blob(q, 1'b0);
      accept();
      send_blob(rand_blob(NUM), 1'b0);
      accept();
      q = rand_blob(1);
      send_blob(q, 1'b0);
      accept();
      send_blob(rand_blob(NUM), 1'b0);
      accept();

      // en gaps
      send_blob(nominal, 1'b1);
      accept();
      for (int k = 0; k < 4; k++) begin
         q = rand_blob(NUM);
         for (int i = 0; i < NUM; i++) q[i] = 16'($urandom_range(0, 65535));
         send_blob(q, 1'b1);
         accept();
      end

      // reset mid-blob: a huge aborted score must leave no trace
      for (int i = 0; i < 5; i++) begin
         blob_din_en = 1'b1;
         blob_din    = (i == 1) ? 16'h7fff : rand_score();
         @(posedge clk); #1;
      end
      blob_din_en = 1'b0;
      rst = 1'b0;
      #1;
      chk("mid_rst_rdy",   32'(blob_din_rdy), 32'd0);
      chk("mid_rst_valid", 32'(class_valid),  32'd0);
      chk("mid_rst_idx",   32'(class_idx),    32'd0);
      chk("mid_rst_score", 32'(class_score),  32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rdy_after_mid_rst", 32'(blob_din_rdy), 32'd1);
      send_blob(rand_blob(NUM), 1'b0);
      accept();

      // back-to-back with class_ready tied high: each result valid exactly one cycle
      class_ready = 1'b1;
      for (int b = 0; b < 3; b++) begin
         send_blob(rand_blob(NUM), 1'b0);
         @(posedge clk); #1;
         chk("b2b_valid_1cyc", 32'(class_valid), 32'd0);
         chk("b2b_rdy", 32'(blob_din_rdy), 32'd1);
      end
      class_ready = 1'b0;
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
